// File: rtl/pc_unit.sv
// Program-counter unit: holds the fetch PC and selects the next PC from sequential,
// branch, jump, register-jump and exception sources. Optional macro: PC_ALIGN_CHECK_EN.
module pc_unit #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned STEP     = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       npc_sel,
   input  logic             br_taken,
   input  logic [15:0]      imm16,
   input  logic [25:0]      imm26,
   input  logic [WIDTH-1:0] ra,
   input  logic             exc,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc4,
   output logic [WIDTH-1:0] pc8,
   output logic             redirect,
   output logic             adel
);

   localparam logic [1:0] SEL_SEQ = 2'b00;
   localparam logic [1:0] SEL_BR  = 2'b01;
   localparam logic [1:0] SEL_J   = 2'b10;
   localparam logic [1:0] SEL_JR  = 2'b11;

   localparam logic [WIDTH-1:0] RESET_PC_W = WIDTH'(RESET_PC);
   localparam logic [WIDTH-1:0] EXC_VEC_W  = WIDTH'(EXC_VEC);
   localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
   localparam logic [WIDTH-1:0] STEP2_W    = WIDTH'(2 * STEP);
   localparam logic [WIDTH-1:0] WORD_MASK  = ~WIDTH'(3);

   logic [WIDTH-1:0] pc_q, pc_d;
   logic             redirect_q, redirect_d;
   logic             adel_q, adel_d;

   logic [WIDTH-1:0] br_off;
   logic [WIDTH-1:0] br_target;
   logic [WIDTH-1:0] j_target;
   logic [WIDTH-1:0] jr_target;
   logic             jr_misaligned;

   assign pc4 = pc_q + STEP_W;
   assign pc8 = pc_q + STEP2_W;

   // Branch offset counts instructions, so scale by 4 after sign extension.
   assign br_off    = {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};
   assign br_target = pc4 + br_off;
   assign j_target  = {pc4[WIDTH-1:28], imm26, 2'b00};

`ifdef PC_ALIGN_CHECK_EN
   assign jr_misaligned = (ra[1:0] != 2'b00);
   assign jr_target     = ra;
`else
   // Without the check the low bits are simply dropped to keep fetch word-aligned.
   assign jr_misaligned = 1'b0;
   assign jr_target     = ra & WORD_MASK;
`endif

   always_comb begin
      pc_d       = pc_q;
      redirect_d = 1'b0;
      adel_d     = 1'b0;
      if (exc) begin
         pc_d       = EXC_VEC_W;
         redirect_d = 1'b1;
      end else if (en) begin
         unique case (npc_sel)
            SEL_SEQ: begin
               pc_d = pc4;
            end
            SEL_BR: begin
               if (br_taken) begin
                  pc_d       = br_target;
                  redirect_d = 1'b1;
               end else begin
                  pc_d = pc4;
               end
            end
            SEL_J: begin
               pc_d       = j_target;
               redirect_d = 1'b1;
            end
            SEL_JR: begin
               redirect_d = 1'b1;
               if (jr_misaligned) begin
                  pc_d   = EXC_VEC_W;
                  adel_d = 1'b1;
               end else begin
                  pc_d = jr_target;
               end
            end
            default: begin
               pc_d = pc4;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q       <= RESET_PC_W;
         redirect_q <= 1'b0;
         adel_q     <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         redirect_q <= redirect_d;
         adel_q     <= adel_d;
      end
   end

   assign pc       = pc_q;
   assign redirect = redirect_q;
   assign adel     = adel_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios followed by random traffic,
// compared against an arithmetic reference model of the next-PC rules.
module tb_pc_unit;

`ifdef PC_ALIGN_CHECK_EN
   localparam bit ALIGN_CHK = 1'b1;
`else
   localparam bit ALIGN_CHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, en, br_taken, exc;
   logic [1:0]  npc_sel;
   logic [15:0] imm16;
   logic [25:0] imm26;
   logic [31:0] ra;
   logic [31:0] pc, pc4, pc8;
   logic        redirect, adel;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_pc;
   logic        m_red, m_adel;

   pc_unit dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .npc_sel  (npc_sel),
      .br_taken (br_taken),
      .imm16    (imm16),
      .imm26    (imm26),
      .ra       (ra),
      .exc      (exc),
      .pc       (pc),
      .pc4      (pc4),
      .pc8      (pc8),
      .redirect (redirect),
      .adel     (adel)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: next PC computed directly from the selection rules.
   task automatic model_edge();
      logic [31:0] seq;
      seq = m_pc + 32'd4;
      if (reset) begin
         m_pc = 32'h0000_3000; m_red = 1'b0; m_adel = 1'b0;
      end else if (exc) begin
         m_pc = 32'h0000_4180; m_red = 1'b1; m_adel = 1'b0;
      end else if (!en) begin
         m_red = 1'b0; m_adel = 1'b0;
      end else begin
         m_adel = 1'b0;
         case (npc_sel)
            2'd0: begin m_pc = seq; m_red = 1'b0; end
            2'd1: begin
               if (br_taken) begin
                  m_pc  = seq + 32'($signed(imm16)) * 32'd4;
                  m_red = 1'b1;
               end else begin
                  m_pc = seq; m_red = 1'b0;
               end
            end
            2'd2: begin
               m_pc  = (seq & 32'hF000_0000) + {6'd0, imm26} * 32'd4;
               m_red = 1'b1;
            end
            default: begin
               m_red = 1'b1;
               if (ALIGN_CHK && (ra % 4 != 0)) begin
                  m_pc = 32'h0000_4180; m_adel = 1'b1;
               end else begin
                  m_pc = ra - (ra % 4);
               end
            end
         endcase
      end
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      chk({tag, ".pc"}, pc, m_pc);
      chk({tag, ".pc4"}, pc4, m_pc + 32'd4);
      chk({tag, ".pc8"}, pc8, m_pc + 32'd8);
      chk({tag, ".redirect"}, {31'd0, redirect}, {31'd0, m_red});
      chk({tag, ".adel"}, {31'd0, adel}, {31'd0, m_adel});
   endtask

   task automatic drive(input logic rst, input logic e, input logic [1:0] sel,
                        input logic bt, input logic [15:0] i16, input logic [25:0] i26,
                        input logic [31:0] r, input logic x);
      reset = rst; en = e; npc_sel = sel; br_taken = bt;
      imm16 = i16; imm26 = i26; ra = r; exc = x;
   endtask

   initial begin
      m_pc = '0; m_red = 1'b0; m_adel = 1'b0;
      drive(1, 1, 0, 0, 0, 0, 0, 0);
      step("reset");
      chk("reset_pc", pc, 32'h0000_3000);

      drive(0, 1, 0, 0, 0, 0, 0, 0);
      step("seq1");
      step("seq2");
      step("seq3");
      chk("seq3_pc", pc, 32'h0000_300C);
      chk("seq3_pc8", pc8, 32'h0000_3014);
      step("seq4");

      drive(0, 1, 1, 1, 16'hFFFC, 0, 0, 0);
      step("br_taken");
      chk("br_taken_pc", pc, 32'h0000_3004);
      chk("br_taken_red", {31'd0, redirect}, 32'd1);
      drive(0, 1, 0, 0, 0, 0, 0, 0);
      step("br_after1");
      step("br_after2");
      step("br_after3");
      drive(0, 1, 1, 0, 16'hFFFC, 0, 0, 0);
      step("br_not");
      chk("br_not_pc", pc, 32'h0000_3014);

      drive(1, 1, 0, 0, 0, 0, 0, 0);
      step("reset2");
      drive(0, 1, 2, 0, 0, 26'h0000C40, 0, 0);
      step("jimm");
      chk("jimm_pc", pc, 32'h0000_3100);
      drive(0, 1, 3, 0, 0, 0, 32'h0000_3040, 0);
      step("jr");
      chk("jr_pc", pc, 32'h0000_3040);

      drive(0, 1, 3, 0, 0, 0, 32'h0000_3008, 0);
      step("jr_stall");
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step("stall");
      chk("stall_pc", pc, 32'h0000_3008);
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      step("exc_stall");
      chk("exc_stall_pc", pc, 32'h0000_4180);

      drive(0, 1, 3, 0, 0, 0, 32'hFFFF_FFFC, 0);
      step("jr_top");
      drive(0, 1, 0, 0, 0, 0, 0, 0);
      step("wrap");
      chk("wrap_pc", pc, 32'h0000_0000);
      drive(0, 1, 1, 1, 16'hFFF0, 0, 0, 0);
      step("br_neg_wrap");
      drive(1, 0, 3, 0, 0, 0, 32'h0000_3042, 1);
      step("reset_exc");
      chk("reset_exc_pc", pc, 32'h0000_3000);

      drive(0, 1, 3, 0, 0, 0, 32'h0000_3042, 0);
      step("jr_mis");
      chk("jr_mis_pc", pc, ALIGN_CHK ? 32'h0000_4180 : 32'h0000_3040);
      chk("jr_mis_adel", {31'd0, adel}, {31'd0, ALIGN_CHK});
      drive(0, 1, 0, 0, 0, 0, 0, 0);
      step("adel_clear");
      drive(0, 1, 3, 0, 0, 0, 32'h0000_3043, 1);
      step("jr_mis_exc");

      for (int i = 0; i < 400; i++) begin
         reset    = ($urandom_range(0, 39) == 0);
         exc      = ($urandom_range(0, 19) == 0);
         en       = ($urandom_range(0, 5) != 0);
         npc_sel  = 2'($urandom_range(0, 3));
         br_taken = 1'($urandom);
         imm16    = 16'($urandom);
         imm26    = 26'($urandom);
         ra       = $urandom;
         if ($urandom_range(0, 2) != 0) ra[1:0] = 2'b00;
         step("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
